// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Multi-cycle unsigned magnitude comparator. Operands are latched on the
//   accepting edge and walked MSB-first, one 2-bit slice per clock. The walk
//   stops at the first unequal slice, and a single registered result is
//   reported together with a one-cycle done pulse.
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset (aborts a compare in flight)
//   start   compare request, accepted only while busy == 0
//   a, b    WIDTH-bit unsigned operands, sampled on the accepting edge
//   busy    compare in progress
//   done    one-cycle pulse: result flags valid/updated
//   a_gt_b  registered result A > B
//   a_lt_b  registered result A < B
//   a_eq_b  registered result A == B (all flags low = no result yet)
module serial_mag_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [IDXW-1:0]   idx;

  logic [1:0]        a_sl;
  logic [1:0]        b_sl;
  logic              sl_gt;
  logic              sl_lt;

  // 2-bit comparator stage: returns {gt, lt}; both low means equal.
  function automatic logic [1:0] cmp2(input logic [1:0] x, input logic [1:0] y);
    logic gt;
    logic lt;
    gt = (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);
    lt = (~x[1] & y[1]) | ((x[1] ~^ y[1]) & ~x[0] & y[0]);
    return {gt, lt};
  endfunction

  // Select the slice under inspection from the registered operands.
  always_comb begin
    a_sl = 2'b00;
    b_sl = 2'b00;
    for (int s = 0; s < int'(NSLICE); s++) begin
      if (idx == IDXW'(s)) begin
        a_sl = a_reg[2*s +: 2];
        b_sl = b_reg[2*s +: 2];
      end
    end
  end

  assign {sl_gt, sl_lt} = cmp2(a_sl, b_sl);

  // Control FSM with registered outputs; flags change only on a completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= IDX_LAST;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (sl_gt || sl_lt) begin
            a_gt_b <= sl_gt;
            a_lt_b <= sl_lt;
            a_eq_b <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (idx == '0) begin
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator
//   Directed bench for serial_mag_comparator (WIDTH=8). A transaction-level
//   model predicts busy/done/flags from plain arithmetic (a>b, a<b, a==b and
//   the position of the highest differing bit); outputs are compared against
//   it every cycle, and per-test literal expectations pin the model.
module tb_serial_mag_comparator;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NSLICE = WIDTH / 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;

  int n_cmp;
  int n_fail;
  int n_done;
  bit chk_en;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Number of slices walked: stops at the slice holding the highest differing bit.
  function automatic int slices_examined(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    int k;
    d = x ^ y;
    k = int'(NSLICE);
    for (int i = 0; i < int'(WIDTH); i++)
      if (d[i]) k = int'(NSLICE) - i / 2;
    return k;
  endfunction

  // Transaction model.
  logic       m_busy;
  logic       m_done;
  logic [2:0] m_flags;   // {gt, lt, eq}
  logic [2:0] m_res;
  int         m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_flags <= 3'b000;
      m_res   <= 3'b000;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_flags <= m_res;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= slices_examined(a, b);
        m_res  <= {a > b, a < b, a == b};
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(m_flags));
      if (done) n_done++;
    end
  end

  // Wait (bounded) for done; n = cycles after the accepting edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_cmp(input string nm, input logic [7:0] aa, input logic [7:0] bb,
                        input int exp_k, input logic [2:0] exp_flags);
    int n;
    @(negedge clk);
    start = 1'b1; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    chk({nm, "_busy0"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'(exp_k));
    chk({nm, "_flags"}, 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(exp_flags));
    @(negedge clk);
    chk({nm, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    n_cmp = 0; n_fail = 0; n_done = 0; chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_outs", 32'({busy, done, a_gt_b, a_lt_b, a_eq_b}), 32'd0);

    // Pin the model's slice count.
    chk("model_k_a5", 32'(slices_examined(8'hA5, 8'h5A)), 32'd1);
    chk("model_k_12", 32'(slices_examined(8'h12, 8'h13)), 32'd4);
    chk("model_k_ff", 32'(slices_examined(8'hFF, 8'hFF)), 32'd4);
    chk("model_k_30", 32'(slices_examined(8'h30, 8'h20)), 32'd2);

    // 1..3: basic gt / lt / eq
    do_cmp("t1", 8'hA5, 8'h5A, 1, 3'b100);
    do_cmp("t2", 8'h12, 8'h13, 4, 3'b010);
    do_cmp("t3", 8'hFF, 8'hFF, 4, 3'b001);
    repeat (3) @(negedge clk);
    chk("t3_hold", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b001);
    do_cmp("t3b", 8'h30, 8'h20, 2, 3'b100);
    do_cmp("t3c", 8'h04, 8'h08, 3, 3'b010);

    // 4: start while busy is ignored
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h13;
    @(negedge clk);
    a = 8'h00; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_lat", 32'(n), 32'd4);
    chk("t4_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b010);
    repeat (6) @(negedge clk);
    chk("t4_ndone", 32'(n_done - d0), 32'd1);

    // 5: reset aborts an in-flight compare
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; a = 8'hC0; b = 8'h40;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst", 32'({busy, done, a_gt_b, a_lt_b, a_eq_b}), 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_nodone", 32'(n_done - d0), 32'd0);
    do_cmp("t5b", 8'h40, 8'hC0, 1, 3'b010);

    // 6: back-to-back, second start accepted in the done cycle
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h00;
    @(negedge clk);
    a = 8'h01; b = 8'h01;
    chk("t6_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t6_done1", 32'({busy, done, a_gt_b, a_lt_b, a_eq_b}), 32'b01100);
    @(negedge clk);
    start = 1'b0;
    chk("t6_busy2", 32'({busy, done}), 32'b10);
    wait_done(n);
    chk("t6_lat2", 32'(n), 32'd4);
    chk("t6_flags2", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b001);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
